// File: rtl/avalon_master_pkg.sv
// avalon_master_pkg: opcodes, FSM states and instruction field offsets for avalon_master
package avalon_master_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_WAIT  = 4'h3;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam int DATA_LSB  = 0;
  localparam int WAIT_BITS = 16;
  typedef enum logic [2:0] {FETCH, WRITE, READ, RDATA, WAIT, HALT} state_t;
  function automatic int addr_lsb(input int data_size);
    return data_size;
  endfunction
  function automatic int opcode_lsb(input int instr_size, input int opcode_size);
    return instr_size - opcode_size;
  endfunction
endpackage

// File: rtl/avalon_master_if.sv
// avalon_master_if: Avalon-MM bus between avalon_master and a slave; waitrequest only with AVM_WAITREQUEST_EN
interface avalon_master_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [ADDRESS_SIZE-1:0] address;
  logic [DATA_SIZE-1:0]    readdata;
  logic [DATA_SIZE-1:0]    writedata;
`ifdef AVM_WAITREQUEST_EN
  logic                    waitrequest;
`endif
  modport master (
    output chipselect, read, write, address, writedata,
    input  readdata
`ifdef AVM_WAITREQUEST_EN
    , input waitrequest
`endif
  );
  modport slave (
    input  chipselect, read, write, address, writedata,
    output readdata
`ifdef AVM_WAITREQUEST_EN
    , output waitrequest
`endif
  );
endinterface

// File: rtl/avm_instr_decode.sv
// avm_instr_decode: splits an instruction word into opcode, address and data fields
module avm_instr_decode
  import avalon_master_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int OPCODE_SIZE  = 4,
  parameter int INSTR_SIZE   = 68
) (
  input  logic [INSTR_SIZE-1:0]   instr,
  output logic [OPCODE_SIZE-1:0]  opcode,
  output logic [ADDRESS_SIZE-1:0] address,
  output logic [DATA_SIZE-1:0]    data
);
  assign opcode  = instr[opcode_lsb(INSTR_SIZE, OPCODE_SIZE) +: OPCODE_SIZE];
  assign address = instr[addr_lsb(DATA_SIZE) +: ADDRESS_SIZE];
  assign data    = instr[DATA_LSB +: DATA_SIZE];
endmodule

// File: rtl/avalon_master.sv
// avalon_master: instruction-table driven Avalon-MM master (WRITE/READ/WAIT/NOP/HALT)
// Optional AVM_WAITREQUEST_EN adds waitrequest stalling of WRITE and READ.
module avalon_master
  import avalon_master_pkg::*;
#(
  parameter int ADDRESS_SIZE     = 32,
  parameter int DATA_SIZE        = 32,
  parameter int OPCODE_SIZE      = 4,
  parameter int INSTR_SIZE       = 68,
  parameter int INSTR_LIMIT_SIZE = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  avalon_master_if.master             avmaster,
  output logic [DATA_SIZE-1:0]        avmaster_readdata_watch,
  output logic [INSTR_LIMIT_SIZE-1:0] programCounter,
  input  logic [INSTR_SIZE-1:0]       instructionVector
);
  localparam int WW = DATA_SIZE < WAIT_BITS ? DATA_SIZE : WAIT_BITS;
  localparam logic [INSTR_LIMIT_SIZE-1:0] PC_MAX = '1;
  state_t                  state, state_n, done;
  logic [OPCODE_SIZE-1:0]  op;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0]    data;
  logic [WAIT_BITS-1:0]    cnt;
  logic                    last, stall;
  avm_instr_decode #(
    .ADDRESS_SIZE(ADDRESS_SIZE), .DATA_SIZE(DATA_SIZE),
    .OPCODE_SIZE(OPCODE_SIZE), .INSTR_SIZE(INSTR_SIZE)
  ) u_dec (
    .instr(instructionVector), .opcode(op), .address(addr), .data(data)
  );
`ifdef AVM_WAITREQUEST_EN
  assign stall = avmaster.waitrequest;
`else
  assign stall = 1'b0;
`endif
  // NOP and unknown opcodes reuse WAIT with a zero count so they cost two cycles
  always_comb begin
    done    = last ? HALT : FETCH;
    state_n = state;
    case (state)
      FETCH:   state_n = op == OPCODE_SIZE'(OP_WRITE) ? WRITE :
                         op == OPCODE_SIZE'(OP_READ)  ? READ  :
                         op == OPCODE_SIZE'(OP_HALT)  ? HALT  : WAIT;
      WRITE:   state_n = stall ? WRITE : done;
      READ:    state_n = stall ? READ : RDATA;
      RDATA:   state_n = done;
      WAIT:    state_n = cnt == '0 ? done : WAIT;
      default: state_n = HALT;
    endcase
  end
  // strobes are registered from the next state so they line up with WRITE/READ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= FETCH;
      cnt                     <= '0;
      last                    <= 1'b0;
      programCounter          <= '0;
      avmaster_readdata_watch <= '0;
      avmaster.chipselect     <= 1'b0;
      avmaster.read           <= 1'b0;
      avmaster.write          <= 1'b0;
      avmaster.address        <= '0;
      avmaster.writedata      <= '0;
    end else begin
      state               <= state_n;
      avmaster.chipselect <= state_n == WRITE || state_n == READ;
      avmaster.write      <= state_n == WRITE;
      avmaster.read       <= state_n == READ;
      if (state == FETCH) begin
        cnt  <= op == OPCODE_SIZE'(OP_WAIT) ? WAIT_BITS'(data[WW-1:0]) : '0;
        last <= programCounter == PC_MAX;
        if (programCounter != PC_MAX) programCounter <= programCounter + 1'b1;
        if (state_n == WRITE || state_n == READ) avmaster.address <= addr;
        if (state_n == WRITE) avmaster.writedata <= data;
      end
      if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == RDATA) avmaster_readdata_watch <= avmaster.readdata;
    end
  end
endmodule

// File: tb/tb_avalon_master.sv
// tb_avalon_master: table-driven program plus scoreboarded Avalon transfers for avalon_master
module tb_avalon_master;
  typedef struct {logic [67:0] instr; int cost;} vec_t;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} xfer_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] watch;
  logic [6:0] pc;
  logic [67:0] ivec;
  logic [67:0] mem [128];
  xfer_t exp_q[$];
  vec_t vt[10];
  int checks = 0, errors = 0, cyc = 0, exp_len = 1;

  avalon_master_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) av ();

  avalon_master dut (
    .clk(clk), .reset(reset), .avmaster(av),
    .avmaster_readdata_watch(watch), .programCounter(pc), .instructionVector(ivec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign ivec = mem[pc];

  function automatic logic [31:0] slave(input logic [31:0] a);
    return a == 32'h20 ? 32'hCAFEF00D : a ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) av.readdata <= av.read ? slave(av.address) : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard / protocol monitor
  int wlen = 0, rlen = 0;
  logic wpend = 1'b0;
  logic [31:0] wexp;
  always @(negedge clk) begin
    if (reset) begin
      wlen = 0; rlen = 0; wpend = 1'b0;
    end else begin
      xfer_t x;
      chk("rw_excl", av.read & av.write, 1'b0);
      chk("cs_match", av.chipselect, av.read | av.write);
      if (wpend) begin
        chk("watch", watch, wexp);
        wpend = 1'b0;
      end
      if ((av.write && wlen == 0) || (av.read && rlen == 0)) begin
        chk("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          chk("sb_kind", av.write, x.wr);
          chk("sb_addr", av.address, x.addr);
          if (av.write) chk("sb_wdata", av.writedata, x.data);
          else wexp = x.data;
        end
      end
      if (av.write) wlen++;
      else if (wlen > 0) begin
        chk("write_len", wlen, exp_len);
        wlen = 0;
      end
      if (av.read) rlen++;
      else if (rlen > 0) begin
        chk("read_len", rlen, exp_len);
        rlen = 0;
        wpend = 1'b1;
      end
    end
  end

  task automatic put(input int idx, input logic [67:0] ins);
    logic [3:0] op;
    mem[idx] = ins;
    op = ins[67:64];
    if (op == 4'h1) exp_q.push_back('{1'b1, ins[63:32], ins[31:0]});
    if (op == 4'h2) exp_q.push_back('{1'b0, ins[63:32], slave(ins[63:32])});
  endtask

  task automatic begin_prog();
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 128; i++) mem[i] = {4'hF, 64'h0};
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_pc(input logic [6:0] target, input int lim, output int t);
    int n = 0;
    while (pc != target && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("pc_reached", pc, target);
    t = cyc;
  endtask

  task automatic run_to_write(input logic [67:0] first, output int n);
    begin_prog();
    put(0, first);
    put(1, 68'h1_00000070_00000070);
    release_reset();
    n = 0;
    while (!av.write && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("write_seen", av.write, 1'b1);
  endtask

  initial begin
    int t, tp, na, nb, n;
    vt = '{'{68'h1_00000010_DEADBEEF, 2}, '{68'h2_00000020_00000000, 3},
           '{68'h0_00000000_00000000, 2}, '{68'h7_00000000_12345678, 2},
           '{68'h3_00000000_00000005, 7}, '{68'h1_00000044_A5A5A5A5, 2},
           '{68'h3_00000000_00000000, 2}, '{68'h2_00000030_00000000, 3},
           '{68'h1_00000050_00000001, 2}, '{68'hF_00000000_00000000, 0}};
`ifdef AVM_WAITREQUEST_EN
    av.waitrequest = 1'b0;
`endif
    begin_prog();
    for (int i = 0; i < 10; i++) put(i, vt[i].instr);
    #20;
    chk("rst_strobes", {av.chipselect, av.read, av.write}, 3'b000);
    chk("rst_pc", pc, 7'd0);
    #20 reset = 1'b0;
    #1;
    chk("rel_strobes", {av.chipselect, av.read, av.write}, 3'b000);
    chk("rel_addr", {av.address, av.writedata}, 64'h0);
    chk("rel_watch", watch, 32'h0);
    chk("rel_pc", pc, 7'd0);
    @(negedge clk);
    chk("first_fetch", pc, 7'd1);
    tp = cyc;
    for (int i = 1; i < 10; i++) begin
      wait_pc(7'(i + 1), 50, t);
      chk($sformatf("cost%0d", i - 1), t - tp, vt[i - 1].cost);
      tp = t;
    end
    repeat (20) @(negedge clk);
    chk("halt_pc", pc, 7'd10);
    chk("halt_strobes", {av.chipselect, av.read, av.write}, 3'b000);
    chk("halt_sb_empty", exp_q.size(), 0);
    chk("halt_watch", watch, slave(32'h30));

    begin_prog();
    put(0, 68'h1_00000001_00000011);
    put(1, 68'h1_00000002_00000022);
    put(2, 68'h7_00000003_00000033);
    put(3, 68'hF_00000000_00000000);
    release_reset();
    wait_pc(7'd4, 50, t);
    repeat (20) @(negedge clk);
    chk("halt3_pc", pc, 7'd4);
    chk("halt3_strobes", {av.chipselect, av.read, av.write}, 3'b000);
    chk("halt3_sb_empty", exp_q.size(), 0);

    run_to_write(68'h0_00000000_00000000, na);
    run_to_write(68'h3_00000000_00000005, nb);
    chk("wait_delay", nb - na, 5);

    begin_prog();
    for (int i = 0; i < 127; i++) put(i, 68'h0);
    put(127, 68'h1_0000007F_0000FEED);
    release_reset();
    wait_pc(7'd127, 400, t);
    repeat (30) @(negedge clk);
    chk("nowrap_pc", pc, 7'd127);
    chk("nowrap_strobes", {av.chipselect, av.read, av.write}, 3'b000);
    chk("nowrap_sb_empty", exp_q.size(), 0);

    begin_prog();
    put(0, 68'h2_00000030_00000000);
    put(1, 68'h2_00000020_00000000);
    release_reset();
    wait_pc(7'd2, 50, t);
    chk("mid_read", av.read, 1'b1);
    chk("watch_pre", watch, slave(32'h30));
    #1 reset = 1'b1;
    #1;
    chk("async_strobes", {av.chipselect, av.read, av.write}, 3'b000);
    chk("async_watch", watch, 32'h0);
    chk("async_pc", pc, 7'd0);

`ifdef AVM_WAITREQUEST_EN
    begin_prog();
    put(0, 68'h1_00000060_00000077);
    exp_len = 4;
    av.waitrequest = 1'b1;
    release_reset();
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (av.write) n++;
      if (n == 4) av.waitrequest = 1'b0;
    end
    chk("wreq_len", n, 4);
    chk("wreq_sb_empty", exp_q.size(), 0);
    exp_len = 1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
